// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's memory stage and dmem_responder.
// master = core side (drives requests), slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, busy, err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, busy, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised synchronous RAM behind a valid/ready
// request channel, with WAIT_STATES programmable wait cycles, a busy stall
// output and a one-cycle response pulse.
// Optional: define DMEM_ACCESS_ERR_EN to flag misaligned / out-of-range
// accesses (errored stores write nothing, errored loads return 0).
module dmem_responder #(
    parameter  int DEPTH_WORDS = 1024,
    parameter  int WAIT_STATES = 1,
    localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                accept;
    logic                commit;
    logic                req_err;

    // captured request, used when the access completes after WAIT
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_idx;
    logic [31:0]         cap_wdata;
    logic [3:0]          cap_be;
    logic                cap_err;

    // access actually performed on the edge that enters RESP
    logic                c_we;
    logic [ADDR_W-1:0]   c_idx;
    logic [31:0]         c_wdata;
    logic [3:0]          c_be;
    logic                c_err;

    logic [31:0]         ram [DEPTH_WORDS];
    logic [31:0]         rdata_q;

`ifdef DMEM_ACCESS_ERR_EN
    assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                     ({1'b0, bus.req_addr} >= (33'(DEPTH_WORDS) << 2));
`else
    // Low bits and bits above the word index are don't-care: addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};
    assign req_err = 1'b0;
`endif

    // Reset gating keeps the bus quiet and the RAM untouched while reset is held.
    assign bus.req_ready  = reset && (state != S_WAIT);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.busy       = (state == S_WAIT);
    assign bus.err        = (state == S_RESP) && cap_err;
    assign bus.resp_rdata = rdata_q;

    assign accept = bus.req_valid && bus.req_ready;
    assign commit = reset && (state_nxt == S_RESP);

    // Next-state and wait counter; IDLE and RESP accept identically (back-to-back).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_RESP: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nxt = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the access completes on its acceptance edge, so
    // the live request feeds the RAM; otherwise the captured copy does.
    always_comb begin
        c_we    = cap_we;
        c_idx   = cap_idx;
        c_wdata = cap_wdata;
        c_be    = cap_be;
        c_err   = cap_err;
        if (state != S_WAIT) begin
            c_we    = bus.req_we;
            c_idx   = bus.req_addr[ADDR_W+1:2];
            c_wdata = bus.req_wdata;
            c_be    = bus.req_be;
            c_err   = req_err;
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request on acceptance so inputs may change during WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_we    <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= 32'd0;
            cap_be    <= 4'd0;
            cap_err   <= 1'b0;
        end else if (accept) begin
            cap_we    <= bus.req_we;
            cap_idx   <= bus.req_addr[ADDR_W+1:2];
            cap_wdata <= bus.req_wdata;
            cap_be    <= bus.req_be;
            cap_err   <= req_err;
        end
    end

    // Load data register: updated only by loads, held across stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rdata_q <= 32'd0;
        else if (commit && !c_we)
            rdata_q <= c_err ? 32'd0 : ram[c_idx];
    end

    // RAM byte-write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && c_we && !c_err) begin
            for (int b = 0; b < 4; b++)
                if (c_be[b]) ram[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT_STATES 1, 0, 3).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and
// compares response cycle, data, err and busy duration.
module tb_dmem_responder;

`ifdef DMEM_ACCESS_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n_v = 3'b000;
    logic [2:0]  vld = 3'b000;
    logic        v_we = 1'b0;
    logic [31:0] v_addr = 32'd0;
    logic [31:0] v_wdata = 32'd0;
    logic [3:0]  v_be = 4'd0;
    logic [2:0]  rdy, rv, bsy, er;
    logic [31:0] rd [3];
    int          ws [3] = '{1, 0, 3};
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          bcnt [3] = '{0, 0, 0};
    logic        ws0_busy_seen = 1'b0;
    exp_t        q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if if_a ();
    dmem_responder_if if_b ();
    dmem_responder_if if_c ();

    assign if_a.req_valid = vld[0];
    assign if_a.req_we    = v_we;
    assign if_a.req_addr  = v_addr;
    assign if_a.req_wdata = v_wdata;
    assign if_a.req_be    = v_be;
    assign if_b.req_valid = vld[1];
    assign if_b.req_we    = v_we;
    assign if_b.req_addr  = v_addr;
    assign if_b.req_wdata = v_wdata;
    assign if_b.req_be    = v_be;
    assign if_c.req_valid = vld[2];
    assign if_c.req_we    = v_we;
    assign if_c.req_addr  = v_addr;
    assign if_c.req_wdata = v_wdata;
    assign if_c.req_be    = v_be;

    assign rdy = {if_c.req_ready,  if_b.req_ready,  if_a.req_ready};
    assign rv  = {if_c.resp_valid, if_b.resp_valid, if_a.resp_valid};
    assign bsy = {if_c.busy,       if_b.busy,       if_a.busy};
    assign er  = {if_c.err,        if_b.err,        if_a.err};
    assign rd[0] = if_a.resp_rdata;
    assign rd[1] = if_b.resp_rdata;
    assign rd[2] = if_c.resp_rdata;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (.clk(clk), .reset(rst_n_v[0]), .bus(if_a));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(rst_n_v[1]), .bus(if_b));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(rst_n_v[2]), .bus(if_c));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic qpop(input int d, output exp_t e);
        case (d)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    // Monitor: compare every response against the scoreboard head.
    task automatic mon(input int d);
        exp_t e;
        if (!rst_n_v[d]) begin
            bcnt[d] = 0;
        end else if (rv[d]) begin
            if (qsize(d) == 0) begin
                chk($sformatf("unexpected_resp_d%0d", d), 32'(rv[d]), 32'd0);
            end else begin
                qpop(d, e);
                chk($sformatf("resp_cycle_d%0d", d), 32'(cyc), 32'(e.cyc));
                chk($sformatf("resp_rdata_d%0d", d), rd[d], e.rdata);
                chk($sformatf("resp_err_d%0d", d), 32'(er[d]), 32'(e.err));
                chk($sformatf("busy_len_d%0d", d), 32'(bcnt[d]), 32'(ws[d]));
                chk($sformatf("busy_in_resp_d%0d", d), 32'(bsy[d]), 32'd0);
            end
            bcnt[d] = 0;
        end else if (bsy[d]) begin
            bcnt[d]++;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) mon(d);
        if (bsy[1]) ws0_busy_seen = 1'b1;
    end

    // Present a request (called just after a posedge), hold it until accepted,
    // and record the expected response. Leaves req_valid asserted.
    task automatic issue(input int d, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input bit push, input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        int   t;
        bit   ok;
        v_we = we; v_addr = a; v_wdata = wd; v_be = be; vld[d] = 1'b1;
        t = 0; ok = 1'b0;
        while (!ok && t < 50) begin
            @(negedge clk);
            if (rdy[d]) ok = 1'b1;
            else t++;
        end
        if (!ok) begin
            chk($sformatf("accept_timeout_d%0d", d), 32'(rdy[d]), 32'd1);
            vld[d] = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        if (push) begin
            e.cyc = cyc + ws[d]; e.rdata = exp_rd; e.err = exp_err;
            qpush(d, e);
        end
    endtask

    task automatic idle(input int d, input int n);
        vld[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d);
        int t = 0;
        while (qsize(d) != 0 && t < 40) begin
            @(posedge clk); t++;
        end
        #1;
        chk($sformatf("drain_d%0d", d), 32'(qsize(d)), 32'd0);
    endtask

    initial begin
        // Reset held: outputs quiet.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_resp_valid", 32'(rv[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chk("rst_err", 32'(er[0]), 32'd0);
        chk("rst_rdata", rd[0], 32'd0);
        @(posedge clk); #1;
        rst_n_v = 3'b111;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", 32'(rdy[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_no_resp", 32'(rv[0]), 32'd0);
        end
        @(posedge clk); #1;

        // WAIT_STATES=1: full and partial stores, loads, error/alias cases.
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0);
        idle(0, 1);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0);
        idle(0, 2);
        issue(0, 1, 32'h10, 32'h12345678, 4'b0011, 1, 32'hDEADBEEF, 0);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEAD5678, 0);
        issue(0, 1, 32'h0, 32'h0BADF00D, 4'hF, 1, 32'hDEAD5678, 0);
        idle(0, 1);
        issue(0, 0, 32'h13, 32'h0, 4'h0, 1, ERR ? 32'h0 : 32'hDEAD5678, ERR);
        idle(0, 1);
        issue(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, ERR ? 32'h0 : 32'hDEAD5678, ERR);
        idle(0, 1);
        issue(0, 0, 32'h0, 32'h0, 4'h0, 1, ERR ? 32'h0BADF00D : 32'hFFFFFFFF, 0);
        issue(0, 1, 32'h10, 32'h0, 4'b0000, 1, ERR ? 32'h0BADF00D : 32'hFFFFFFFF, 0);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 1, 32'hDEAD5678, 0);
        idle(0, 1);
        drain(0);

        // WAIT_STATES=0: back-to-back store/load with valid held throughout.
        issue(1, 1, 32'h20, 32'hA5A5A5A5, 4'hF, 1, 32'h0, 0);
        issue(1, 0, 32'h20, 32'h0, 4'h0, 1, 32'hA5A5A5A5, 0);
        idle(1, 2);
        drain(1);
        chk("ws0_busy_never", 32'(ws0_busy_seen), 32'd0);

        // WAIT_STATES=3: reset mid-WAIT aborts a store.
        issue(2, 1, 32'h30, 32'hCAFEF00D, 4'hF, 1, 32'h0, 0);
        idle(2, 1);
        drain(2);
        issue(2, 1, 32'h30, 32'h11111111, 4'hF, 0, 32'h0, 0);
        vld[2] = 1'b0;
        @(negedge clk);
        chk("ws3_busy_in_wait", 32'(bsy[2]), 32'd1);
        rst_n_v[2] = 1'b0;
        @(negedge clk);
        chk("ws3_rst_resp_valid", 32'(rv[2]), 32'd0);
        chk("ws3_rst_busy", 32'(bsy[2]), 32'd0);
        chk("ws3_rst_ready", 32'(rdy[2]), 32'd0);
        @(posedge clk); #1;
        rst_n_v[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ws3_no_resp_after_rst", 32'(rv[2]), 32'd0);
        end
        @(posedge clk); #1;
        issue(2, 0, 32'h30, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0);
        idle(2, 1);
        drain(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
